decoder_iter_ctrl: RTL

DECODER_ITER_CTRL -- requirements
Module: decoder_iter_ctrl

---
 rtl/decoder_iter_ctrl_if.sv | 31 +++
 rtl/decoder_iter_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/decoder_iter_ctrl_if.sv
// Handshake and control bundle between the iterative decoder controller and its
// datapath/producer/consumer; master is the controller side.
interface decoder_iter_ctrl_if #(
  parameter int ITER_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic              llr_load;
  logic              layer_en;
  logic              feedback_sel;
  logic              msg_capture;
  logic [ITER_W-1:0] iter_cnt;
  logic              syndrome_ok;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic              out_early;
  logic [ITER_W-1:0] out_iters;

  modport master (
    input  in_valid, syndrome_ok, flush, out_ready,
    output in_ready, llr_load, layer_en, feedback_sel, msg_capture,
           iter_cnt, out_valid, out_early, out_iters
  );

  modport slave (
    output in_valid, syndrome_ok, flush, out_ready,
    input  in_ready, llr_load, layer_en, feedback_sel, msg_capture,
           iter_cnt, out_valid, out_early, out_iters
  );
endinterface

// File: rtl/decoder_iter_ctrl.sv
// Iteration controller for a layered LDPC-style decoder: load, iterate, check, report.
// Optional early termination on syndrome is enabled by defining DECODER_EARLY_TERM_EN.
module decoder_iter_ctrl #(
  parameter int N_ITER    = 5,
  parameter int LAYER_LAT = 2,
  parameter int ITER_W    = 4
) (
  input logic                 clk,
  input logic                 rst,
  decoder_iter_ctrl_if.master bus
);

  localparam int LAT_W = (LAYER_LAT > 1) ? $clog2(LAYER_LAT) : 1;
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(LAYER_LAT - 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(N_ITER - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CHECK,
    DONE
  } state_t;

  state_t            state;
  logic [LAT_W-1:0]  lat_cnt;
  logic [ITER_W-1:0] iter_q;
  logic [ITER_W-1:0] out_iters_q;
  logic              out_early_q;
  logic              out_valid_q;
  logic              llr_load_q;
  logic              layer_en_q;
  logic              msg_capture_q;
  logic              feedback_sel_q;
  logic              in_ready_q;
  logic              early_exit;

`ifdef DECODER_EARLY_TERM_EN
  assign early_exit = bus.syndrome_ok;
`else
  logic unused_syndrome;
  assign unused_syndrome = bus.syndrome_ok;
  assign early_exit      = 1'b0;
`endif

  // Every output is a register updated together with the state it belongs to,
  // so strobes line up exactly with the state they are decoded from.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      lat_cnt        <= '0;
      iter_q         <= '0;
      out_iters_q    <= '0;
      out_early_q    <= 1'b0;
      out_valid_q    <= 1'b0;
      llr_load_q     <= 1'b0;
      layer_en_q     <= 1'b0;
      msg_capture_q  <= 1'b0;
      feedback_sel_q <= 1'b0;
      in_ready_q     <= 1'b0;
    end else if (bus.flush) begin
      state          <= IDLE;
      lat_cnt        <= '0;
      iter_q         <= '0;
      out_iters_q    <= '0;
      out_early_q    <= 1'b0;
      out_valid_q    <= 1'b0;
      llr_load_q     <= 1'b0;
      layer_en_q     <= 1'b0;
      msg_capture_q  <= 1'b0;
      feedback_sel_q <= 1'b0;
      in_ready_q     <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_ready_q && bus.in_valid) begin
            state      <= LOAD;
            in_ready_q <= 1'b0;
            llr_load_q <= 1'b1;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        LOAD: begin
          state          <= RUN;
          llr_load_q     <= 1'b0;
          iter_q         <= '0;
          lat_cnt        <= '0;
          layer_en_q     <= 1'b1;
          feedback_sel_q <= 1'b0;
        end
        RUN: begin
          if (lat_cnt == LAT_LAST) begin
            state         <= CHECK;
            lat_cnt       <= '0;
            msg_capture_q <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        CHECK: begin
          msg_capture_q <= 1'b0;
          // A satisfied syndrome wins over the iteration limit, so out_early
          // reports it even on the last permitted iteration.
          if (early_exit || (iter_q == ITER_LAST)) begin
            state          <= DONE;
            layer_en_q     <= 1'b0;
            feedback_sel_q <= 1'b0;
            out_valid_q    <= 1'b1;
            out_iters_q    <= iter_q + ITER_W'(1);
            out_early_q    <= early_exit;
          end else begin
            state          <= RUN;
            iter_q         <= iter_q + ITER_W'(1);
            feedback_sel_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            out_iters_q <= '0;
            out_early_q <= 1'b0;
            iter_q      <= '0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.llr_load     = llr_load_q;
  assign bus.layer_en     = layer_en_q;
  assign bus.feedback_sel = feedback_sel_q;
  assign bus.msg_capture  = msg_capture_q;
  assign bus.iter_cnt     = iter_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_early    = out_early_q;
  assign bus.out_iters    = out_iters_q;

endmodule
